cic_comb_upsampler: RTL and testbench
=====================================

Name: cic_comb_upsampler

Overview:
- Upstream half of the CIC interpolation filter in the sigma-delta DAC path: N comb stages at the low (input) rate followed by a 1:RATE zero-stuffing upsampler.
- Accepts input samples over a valid/ready handshake.
- On every high-rate tick it emits one sample plus a strobe, which directly drive the ena/in of the first integrator stage of the chain.

Parameters:
- IN_WIDTH, 16, signed input sample width.
- N_STAGES, 3, number of comb stages (1..8); differential delay fixed at 1.
- RATE, 8, interpolation ratio (2..256).
- Derived localparam OUT_WIDTH = IN_WIDTH + N_STAGES; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  high-rate sample strobe, one pulse per output sample
- in_data  in  IN_WIDTH  signed input sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept in_data this cycle
- out_data  out  OUT_WIDTH  signed upsampled comb output, to integrator chain
- out_ena  out  1  one-cycle strobe, out_data updated this cycle
- underrun  out  1  sticky: sample needed but none buffered

Behaviour:
- Reset (rst=1, synchronous, active-high, clock clk):
  - All comb delay registers cleared to 0.
  - Input buffer emptied.
  - Phase counter = 0.
  - out_data = 0, out_ena = 0, underrun = 0.
  - Reset mid-operation discards any buffered sample and restarts at phase 0 with no residue in comb state.
- Input buffer: one-entry register (buf_data, buf_full).
  - in_ready = !buf_full | consume, where consume = tick & (phase==0).
  - Transfer occurs when in_valid & in_ready.
  - Simultaneous consume and transfer: the buffer is reloaded with the new sample; buf_full stays 1.
- Phase counter: 0..RATE-1, advances only on tick, wraps RATE-1 -> 0.
- On tick with phase==0:
  - Comb input x = sign-extended buf_data if buf_full.
  - Otherwise x = 0 and underrun is set (sticky until rst).
  - Comb state is still advanced with x, so the filter stays consistent.
- Comb stage k (k=1..N_STAGES):
  - Operates at width IN_WIDTH+k.
  - y_k = x_k - d_k; then d_k <= x_k on consume only.
  - Stage input is the sign-extended previous output.
  - Two's-complement wrap, no saturation (required for CIC correctness).
  - The comb chain is combinational within the consume cycle.
- Output:
  - On every tick, the registered out_data is updated one cycle later, together with out_ena=1 for exactly one cycle.
  - At phase 0: out_data = y_N.
  - At phases 1..RATE-1: out_data = 0 (zero stuffing).
  - Latency: tick at cycle t -> out_data/out_ena valid at cycle t+1.
  - Without tick: out_ena = 0 and out_data holds its value.
- Back-to-back ticks (tick every cycle) are legal; throughput is one output per tick.
- tick during rst is ignored.

Optional Feature:
- Macro CIC_ZOH_EN.
- Defined:
  - Zero-order hold instead of zero stuffing: at phases 1..RATE-1, out_data repeats the most recent phase-0 value.
  - This adds a hold register, reset to 0.
  - Downstream gain rises by RATE; the integrator chain width must allow for it.
- Undefined: zero stuffing as above, and no hold register is synthesized.

Test Plan (IN_WIDTH=16, N_STAGES=3, RATE=4, tick every cycle, input always supplied unless stated):
- Impulse: samples 1,0,0,0,0... -> out_data stream 1,0,0,0,-3,0,0,0,3,0,0,0,-1,0,0,0, then all 0; out_ena high every cycle after the first tick.
- Step: constant 100 -> phase-0 outputs 100,-200,100,0,0,...; all other phases 0.
- Full scale: constant -32768 -> phase-0 outputs -32768, 65536, -32768, 0; no wrap in the 19-bit output.
- Underrun: withhold in_valid across one phase-0 tick -> underrun rises in the consume cycle and stays 1; that output is the comb response to a zero sample; in_ready stays 1 throughout.
- Handshake/backpressure: tick once every 3 cycles with in_valid held high -> in_ready drops after one accepted sample; exactly one sample is accepted per RATE ticks; no sample is lost or duplicated, as checked against a reference model.
- Reset mid-stream: assert rst at phase 2 after the impulse -> the next cycle shows out_data=0, out_ena=0, underrun=0; a following impulse reproduces the 1,-3,3,-1 sequence exactly. With CIC_ZOH_EN defined, the impulse case gives 1,1,1,1,-3,-3,-3,-3,...

Source files
------------

// File: rtl/cic_comb_upsampler.sv
// cic_comb_upsampler
// Upstream half of a CIC interpolator: N_STAGES comb sections running at the
// input rate, followed by a 1:RATE upsampler that emits one sample per tick.
// Input samples arrive over a valid/ready handshake into a one-entry buffer.
// The output drives the ena/in of the first integrator stage.
//
// Optional build macro CIC_ZOH_EN: zero-order hold instead of zero stuffing.
// At phases 1..RATE-1 the output repeats the last phase-0 value, which raises
// the downstream gain by RATE. Without the macro the non-zero phases output 0
// and no hold register exists.
module cic_comb_upsampler #(
  parameter int IN_WIDTH = 16,
  parameter int N_STAGES = 3,
  parameter int RATE     = 8,
  localparam int OUT_WIDTH = IN_WIDTH + N_STAGES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_ena,
  output logic                        underrun
);

  localparam int PH_W = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATE - 1);

  logic [PH_W-1:0]             phase_p0;
  logic signed [IN_WIDTH-1:0]  buf_data;
  logic                        buf_full;
  logic                        consume;
  logic                        xfer;
  logic signed [OUT_WIDTH-1:0] comb_out_p0;
  logic signed [OUT_WIDTH-1:0] fill_p0;

  // A sample is pulled from the buffer on the phase-0 tick; the buffer may
  // be refilled in that same cycle so back-to-back input is possible.
  assign consume  = tick & (phase_p0 == '0);
  assign in_ready = ~buf_full | consume;
  assign xfer     = in_valid & in_ready;

  // Phase counter: advances only on tick, wraps at RATE-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_p0 <= '0;
    end else if (tick) begin
      phase_p0 <= (phase_p0 == PH_LAST) ? '0 : phase_p0 + 1'b1;
    end
  end

  // Buffer payload: loaded on every accepted transfer.
  always_ff @(posedge clk) begin
    if (xfer) begin
      buf_data <= in_data;
    end
  end

  // Buffer occupancy: a simultaneous reload keeps it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
    end else if (xfer) begin
      buf_full <= 1'b1;
    end else if (consume) begin
      buf_full <= 1'b0;
    end
  end

  // Sticky underrun flag: a phase-0 tick found the buffer empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (consume && !buf_full) begin
      underrun <= 1'b1;
    end
  end

  // ---- stage p0: combinational comb chain, evaluated in the consume cycle ----
  // Stage k takes an (IN_WIDTH+k-1)-bit input and produces IN_WIDTH+k bits,
  // so the difference never needs saturation; arithmetic is plain two's
  // complement as the integrators downstream rely on exact wrap behaviour.
  // A missing sample is fed as zero so the delay line stays consistent.
  for (genvar k = 1; k <= N_STAGES; k++) begin : g_comb
    localparam int W = IN_WIDTH + k;

    logic signed [W-2:0] x_p0;
    logic signed [W-2:0] d_p0;
    logic signed [W-1:0] y_p0;

    if (k == 1) begin : g_first
      assign x_p0 = buf_full ? buf_data : '0;
    end else begin : g_next
      assign x_p0 = g_comb[k-1].y_p0;
    end

    assign y_p0 = {x_p0[W-2], x_p0} - {d_p0[W-2], d_p0};

    // Differential delay of one input-rate sample, advanced on consume only.
    always_ff @(posedge clk) begin
      if (rst) begin
        d_p0 <= '0;
      end else if (consume) begin
        d_p0 <= x_p0;
      end
    end
  end

  assign comb_out_p0 = g_comb[N_STAGES].y_p0;

`ifdef CIC_ZOH_EN
  logic signed [OUT_WIDTH-1:0] hold_p1;

  // Hold register: remembers the latest phase-0 comb output for repetition.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_p1 <= '0;
    end else if (consume) begin
      hold_p1 <= comb_out_p0;
    end
  end

  assign fill_p0 = hold_p1;
`else
  assign fill_p0 = '0;
`endif

  // ---- stage p1: registered output, one cycle after the tick ----
  // Strobe follows every tick; data holds its value between ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ena  <= 1'b0;
      out_data <= '0;
    end else begin
      out_ena <= tick;
      if (tick) begin
        out_data <= (phase_p0 == '0) ? comb_out_p0 : fill_p0;
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_upsampler.sv
// Directed testbench for cic_comb_upsampler (IN_WIDTH=16, N_STAGES=3, RATE=4).
// Expected phase-0 outputs are third-order differences of the input sequence,
// worked out by hand; other phases expand them by zero stuffing or hold.
module tb_cic_comb_upsampler;

  localparam int IW = 16;
  localparam int NS = 3;
  localparam int RT = 4;
  localparam int OW = IW + NS;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 tick;
  logic signed [IW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_ena;
  logic                 underrun;

  int  checks  = 0;
  int  passes  = 0;
  int  fails   = 0;
  int  q[$];
  int  e0[$];
  int  pad     = 0;
  int  acc_cnt = 0;
  bit  rdy_seen;

  cic_comb_upsampler #(
    .IN_WIDTH (IW),
    .N_STAGES (NS),
    .RATE     (RT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_ena  (out_ena),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected value at a given phase for a group whose phase-0 output is v0.
  function automatic int zexp(input int v0, input int ph);
    int r;
    r = (ph == 0) ? v0 : 0;
`ifdef CIC_ZOH_EN
    r = v0;
`endif
    return r;
  endfunction

  task automatic set4(input int a, input int b, input int c, input int d);
    e0.delete();
    e0.push_back(a);
    e0.push_back(b);
    e0.push_back(c);
    e0.push_back(d);
  endtask

  // One clock cycle: drive inputs, note the handshake, advance past the edge.
  task automatic cyc(input bit t, input bit v);
    bit acc;
    tick     = t;
    in_valid = v;
    in_data  = (q.size() > 0) ? IW'(q[0]) : IW'(pad);
    #1;
    rdy_seen = in_ready;
    acc      = v && in_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      acc_cnt++;
      if (q.size() > 0) void'(q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    tick     = 1'b1;
    in_valid = 1'b1;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    tick     = 1'b0;
    in_valid = 1'b0;
    q.delete();
    pad = 0;
  endtask

  task automatic run_ticks(input string tag, input int exp0[$], input int n);
    for (int i = 0; i < n; i++) begin
      int v0;
      v0 = (i / RT < exp0.size()) ? exp0[i / RT] : 0;
      cyc(1'b1, 1'b1);
      chk($sformatf("%s_d%0d", tag, i), out_data, zexp(v0, i % RT));
      chk($sformatf("%s_e%0d", tag, i), out_ena, 1);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset state
    do_reset();
    #1;
    chk("rst_data", out_data, 0);
    chk("rst_ena", out_ena, 0);
    chk("rst_und", underrun, 0);
    chk("rst_rdy", in_ready, 1);

    // Impulse
    q.push_back(1);
    cyc(1'b0, 1'b1);
    chk("imp_pre_ena", out_ena, 0);
    set4(1, -3, 3, -1);
    run_ticks("imp", e0, 20);
    chk("imp_und", underrun, 0);

    // Reset mid-stream with a tick at phase 2; residue must be cleared
    do_reset();
    q.push_back(1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("mid_d0", out_data, 1);
    cyc(1'b1, 1'b1);
    chk("mid_d1", out_data, zexp(1, 1));
    rst = 1'b1; tick = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; tick = 1'b0; in_valid = 1'b0;
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ena", out_ena, 0);
    chk("mid_rst_und", underrun, 0);
    q.delete();
    q.push_back(1);
    pad = 0;
    cyc(1'b0, 1'b1);
    set4(1, -3, 3, -1);
    run_ticks("imp2", e0, 20);

    // Step of 100
    do_reset();
    pad = 100;
    cyc(1'b0, 1'b1);
    set4(100, -200, 100, 0);
    run_ticks("step", e0, 16);

    // Full-scale negative step
    do_reset();
    pad = -32768;
    cyc(1'b0, 1'b1);
    set4(-32768, 65536, -32768, 0);
    run_ticks("full", e0, 16);

    // Underrun: input 5, then one missing sample, then 5 again
    do_reset();
    pad = 5;
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      chk($sformatf("ur_d%0d", i), out_data, zexp((i < 4) ? 5 : -15, i % RT));
      chk($sformatf("ur_rdy%0d", i), rdy_seen, 1);
      chk($sformatf("ur_flag%0d", i), underrun, (i < 4) ? 0 : 1);
    end
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, 1'b1);
      chk($sformatf("ur_hold%0d", i), out_data, zexp(-15, i));
    end
    cyc(1'b1, 1'b1);
    chk("ur_resume", out_data, 20);
    chk("ur_sticky", underrun, 1);

    // Backpressure: tick every third cycle, in_valid held high
    do_reset();
    q.push_back(10); q.push_back(30); q.push_back(20);
    q.push_back(-40); q.push_back(7);
    cyc(1'b0, 1'b1);
    acc_cnt = 0;
    set4(10, 0, -40, -20);
    for (int g = 0; g < 4; g++) begin
      for (int ph = 0; ph < RT; ph++) begin
        cyc(1'b1, 1'b1);
        chk($sformatf("bp_d%0d_%0d", g, ph), out_data, zexp(e0[g], ph));
        chk($sformatf("bp_e%0d_%0d", g, ph), out_ena, 1);
        cyc(1'b0, 1'b1);
        chk($sformatf("bp_idle_e%0d_%0d", g, ph), out_ena, 0);
        chk($sformatf("bp_idle_d%0d_%0d", g, ph), out_data, zexp(e0[g], ph));
        if (g == 0 && ph == 0) chk("bp_rdy_low", rdy_seen, 0);
        cyc(1'b0, 1'b1);
      end
    end
    chk("bp_accepted", acc_cnt, 4);
    chk("bp_left", q.size(), 0);
    chk("bp_und", underrun, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
